cpu54_ctrl_fsm: RTL and testbench
=================================

# cpu54_ctrl_fsm

Multi-cycle control unit that sits on the producing side of the ALU's `ALUC`/flag interface. It accepts one 32-bit MIPS instruction at a time and decodes it. It then sequences the instruction through DECODE/EXEC/MEM/WB, driving ALU operation codes, operand selects, register-file and data-memory strobes, and PC control. It consumes the ALU `zero`/`negative` flags to resolve branches and SLT-class writeback.

## Interface
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `instr`  in  32  instruction word; sampled on accept.
- `instr_valid`  in  1  instruction available.
- `instr_ready`  out  1  high only in IDLE.
- `alu_zero`  in  1  ALU zero flag.
- `alu_negative`  in  1  ALU signed/unsigned less-than flag.
- `aluc`  out  4  ALU op, using the codebase's ALU encoding: ADDU 0000, SUBU 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, LUI 1000, SLTU 1010, SLT 1011, SRA 1100, SRL 1101, SLL 1110.
- `srca_sel`  out  1  0 = rs value, 1 = shamt zero-extended from `instr[10:6]`.
- `srcb_sel`  out  2  0 = rt value, 1 = imm16 sign-extended, 2 = imm16 zero-extended.
- `rf_raddr1`, `rf_raddr2`  out  5  rs, rt.
- `rf_waddr`  out  5  write address: rd for R-type, rt for I-type, 31 for jal.
- `rf_we`  out  1  register write strobe.
- `wb_sel`  out  2  0 = ALU, 1 = {31'b0,`slt_bit`}, 2 = memory, 3 = link (PC+4).
- `slt_bit`  out  1  registered `alu_negative` from EXEC.
- `dmem_re`, `dmem_we`  out  1  data-memory strobes.
- `pc_load`  out  1  one-cycle pulse; equals `done`.
- `pc_sel`  out  2  0 = SEQ, 1 = BRANCH, 2 = JUMP, 3 = REG (jr).
- `done`  out  1  final cycle of the instruction.
- `illegal`  out  1  unsupported instruction; pulses with `done`.

## Operation
- Supported instructions:
  - R-type: addu, add, subu, sub, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr.
  - I-type: addi, addiu, andi, ori, xori, lui, slti, sltiu, lw, sw, beq, bne.
  - J-type: j, jal.
- States:
  - IDLE: `instr_ready=1`; an accept (`instr_valid`) latches `instr` and moves to DECODE.
  - DECODE: classify the instruction. Illegal → IDLE with `done`+`illegal`; otherwise → EXEC.
  - EXEC: `aluc` and selects driven. Branch/jump/jr/jal finish here (→ IDLE); lw/sw → MEM; everything else → WB.
  - MEM: sw asserts `dmem_we` and finishes; lw asserts `dmem_re` → WB.
  - WB: `rf_we` asserted, then finish.
- Operand rules:
  - sll/srl/sra: `srca_sel=1`.
  - Variable shifts: `srca_sel=0`, with B = rt.
  - andi/ori/xori/lui: `srcb_sel=2`.
  - addi/addiu/slti/sltiu/lw/sw: `srcb_sel=1`; sltiu compares the sign-extended immediate unsigned.
  - lw/sw: `aluc=ADDU`.
  - beq/bne: `aluc=SUBU`, B = rt.
- Branch resolution happens in EXEC, combinationally from live flags. beq takes BRANCH iff `alu_zero`; bne iff `!alu_zero`. Otherwise `pc_sel=SEQ`.
- slt/sltu/slti/sltiu: `slt_bit` captures `alu_negative` at the end of EXEC; WB uses `wb_sel=1`.
- add/addi/sub: no overflow trap; the ALU overflow output is not consumed.
- jal: in EXEC, `rf_we=1`, `rf_waddr=31`, `wb_sel=3`, `pc_sel=JUMP`. j: `pc_sel=JUMP`. jr: `pc_sel=REG`.
- `rf_we` is suppressed whenever `rf_waddr==0`.

## Timing
- Accept edge = cycle 0; DECODE = c1, EXEC = c2.
- Finish cycles:
  - ALU ops: WB at c3.
  - Branch/j/jr/jal: c2.
  - sw: c3.
  - lw: MEM c3, WB c4.
  - Illegal: c1.
- All outputs are Moore, decoded from state plus the latched instruction. The exception is `pc_sel` in EXEC for beq/bne, which is combinational from `alu_zero`.
- `instr_valid` while not in IDLE is ignored. There is no buffering.
- Reset values: state IDLE, `instr_ready=1`, `aluc=0000`, all selects 0, `slt_bit=0`, and every strobe (`rf_we`, `dmem_*`, `pc_load`, `done`, `illegal`) 0.
- Reset mid-instruction: all strobes are gated by `!rst` in the cycle `rst` is high; IDLE follows at the next edge. The aborted instruction produces no `done`.

## Structure
- Shared package `cpu54_pkg`: ALUC constants, opcode/funct constants, state enum, and the `srcb_sel`/`wb_sel`/`pc_sel` encodings.
- One combinational sub-module `cpu54_ctrl_decode`: instruction → class, `aluc`, selects, waddr, illegal. The FSM wraps it.

## Test plan
- add $3,$1,$2 (0x00221820): c2 `aluc=0010`, `srcb_sel=0`; c3 `rf_we=1`, `rf_waddr=3`, `wb_sel=0`, `done=1`, `pc_sel=SEQ`.
- slt $3,$1,$2 (0x0022182A), `alu_negative=1` in c2: c3 `wb_sel=1`, `slt_bit=1`. Repeat with 0 → `slt_bit=0`.
- beq $1,$2,4 (0x10220004): `alu_zero=1` → c2 `aluc=0001`, `pc_sel=1`, `done`. `alu_zero=0` → `pc_sel=0`. Same for bne with the flag inverted.
- lw $5,8($4) (0x8C850008): c2 `aluc=0000`, `srcb_sel=1`; c3 `dmem_re`; c4 `rf_we`, `rf_waddr=5`, `wb_sel=2`.
- Illegal opcode (0x7C000000): c1 `done=1`, `illegal=1`; no `rf_we`/`dmem_*`. Back-to-back `instr_valid` is accepted only in IDLE.
- sw $5,8($4) (0xAC850008) with `rst=1` in c3: `dmem_we` stays 0, c4 IDLE, `instr_ready=1`. Separately, jal (0x0C000010): c2 `rf_we`, `rf_waddr=31`, `wb_sel=3`, `pc_sel=2`.

Source files
------------

// File: rtl/cpu54_pkg.sv
// Shared definitions for the cpu54 multi-cycle control unit: ALU op codes,
// MIPS opcode/funct fields, FSM states and the select encodings.
package cpu54_pkg;

  // ALU operation codes
  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_LUI  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1010;
  localparam logic [3:0] ALUC_SLT  = 4'b1011;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;
  localparam logic [3:0] ALUC_SRL  = 4'b1101;
  localparam logic [3:0] ALUC_SLL  = 4'b1110;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Instruction classes drive the state walk and the writeback source
  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_SLT     = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BEQ     = 4'd4,
    CLS_BNE     = 4'd5,
    CLS_J       = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JR      = 4'd8,
    CLS_ILLEGAL = 4'd9
  } instr_class_e;

  typedef enum logic [1:0] {
    SRCB_RT   = 2'd0,
    SRCB_SIMM = 2'd1,
    SRCB_ZIMM = 2'd2
  } srcb_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_SLT  = 2'd1,
    WB_MEM  = 2'd2,
    WB_LINK = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_REG    = 2'd3
  } pc_sel_e;

  typedef struct packed {
    instr_class_e cls;
    logic [3:0]   aluc;
    logic         srcaSel;
    srcb_sel_e    srcbSel;
    logic [4:0]   waddr;
    logic         illegal;
  } decode_t;

  // Registered control outputs of the FSM
  typedef struct packed {
    logic       ready;
    logic [3:0] aluc;
    logic       srcaSel;
    srcb_sel_e  srcbSel;
    logic [4:0] raddr1;
    logic [4:0] raddr2;
    logic [4:0] waddr;
    logic       rfWe;
    wb_sel_e    wbSel;
    logic       dmemRe;
    logic       dmemWe;
    pc_sel_e    pcSel;
    logic       done;
    logic       illegal;
  } ctrl_out_t;

  // Output values while parked in IDLE (also the reset values)
  function automatic ctrl_out_t idleOutputs();
    ctrl_out_t o;
    o       = '0;
    o.ready = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/cpu54_ctrl_decode.sv
// Combinational instruction decoder: classifies the word and produces the
// ALU op, operand selects and register write address.
module cpu54_ctrl_decode
  import cpu54_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  input  logic [5:0] funct_i,
  output decode_t    dec_o
);

  instr_class_e cls;
  logic [3:0]   aluc;
  logic         srcaSel;
  srcb_sel_e    srcbSel;
  logic [4:0]   waddr;

  // Opcode/funct lookup; anything not listed falls through as illegal
  always_comb begin
    cls     = CLS_ILLEGAL;
    aluc    = ALUC_ADDU;
    srcaSel = 1'b0;
    srcbSel = SRCB_RT;
    waddr   = rt_i;
    case (opcode_i)
      OP_RTYPE: begin
        waddr = rd_i;
        cls   = CLS_ALU;
        case (funct_i)
          FN_ADD:  aluc = ALUC_ADD;
          FN_ADDU: aluc = ALUC_ADDU;
          FN_SUB:  aluc = ALUC_SUB;
          FN_SUBU: aluc = ALUC_SUBU;
          FN_AND:  aluc = ALUC_AND;
          FN_OR:   aluc = ALUC_OR;
          FN_XOR:  aluc = ALUC_XOR;
          FN_NOR:  aluc = ALUC_NOR;
          FN_SLT:  begin aluc = ALUC_SLT;  cls = CLS_SLT; end
          FN_SLTU: begin aluc = ALUC_SLTU; cls = CLS_SLT; end
          FN_SLL:  begin aluc = ALUC_SLL;  srcaSel = 1'b1; end
          FN_SRL:  begin aluc = ALUC_SRL;  srcaSel = 1'b1; end
          FN_SRA:  begin aluc = ALUC_SRA;  srcaSel = 1'b1; end
          FN_SLLV: aluc = ALUC_SLL;
          FN_SRLV: aluc = ALUC_SRL;
          FN_SRAV: aluc = ALUC_SRA;
          FN_JR:   cls  = CLS_JR;
          default: cls  = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI:  begin cls = CLS_ALU;   aluc = ALUC_ADD;  srcbSel = SRCB_SIMM; end
      OP_ADDIU: begin cls = CLS_ALU;   aluc = ALUC_ADDU; srcbSel = SRCB_SIMM; end
      OP_SLTI:  begin cls = CLS_SLT;   aluc = ALUC_SLT;  srcbSel = SRCB_SIMM; end
      OP_SLTIU: begin cls = CLS_SLT;   aluc = ALUC_SLTU; srcbSel = SRCB_SIMM; end
      OP_ANDI:  begin cls = CLS_ALU;   aluc = ALUC_AND;  srcbSel = SRCB_ZIMM; end
      OP_ORI:   begin cls = CLS_ALU;   aluc = ALUC_OR;   srcbSel = SRCB_ZIMM; end
      OP_XORI:  begin cls = CLS_ALU;   aluc = ALUC_XOR;  srcbSel = SRCB_ZIMM; end
      OP_LUI:   begin cls = CLS_ALU;   aluc = ALUC_LUI;  srcbSel = SRCB_ZIMM; end
      OP_LW:    begin cls = CLS_LOAD;  aluc = ALUC_ADDU; srcbSel = SRCB_SIMM; end
      OP_SW:    begin cls = CLS_STORE; aluc = ALUC_ADDU; srcbSel = SRCB_SIMM; end
      OP_BEQ:   begin cls = CLS_BEQ;   aluc = ALUC_SUBU; end
      OP_BNE:   begin cls = CLS_BNE;   aluc = ALUC_SUBU; end
      OP_J:     cls = CLS_J;
      OP_JAL:   begin cls = CLS_JAL;   waddr = LINK_REG; end
      default:  cls = CLS_ILLEGAL;
    endcase
  end

  assign dec_o = '{cls: cls, aluc: aluc, srcaSel: srcaSel, srcbSel: srcbSel,
                   waddr: waddr, illegal: (cls == CLS_ILLEGAL)};

endmodule

// File: rtl/cpu54_ctrl_fsm.sv
// Multi-cycle control FSM: accepts one instruction at a time and walks it
// through DECODE/EXEC/MEM/WB, producing registered Moore control outputs.
module cpu54_ctrl_fsm
  import cpu54_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        alu_zero_i,
  input  logic        alu_negative_i,
  output logic [3:0]  aluc_o,
  output logic        srca_sel_o,
  output logic [1:0]  srcb_sel_o,
  output logic [4:0]  rf_raddr1_o,
  output logic [4:0]  rf_raddr2_o,
  output logic [4:0]  rf_waddr_o,
  output logic        rf_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        slt_bit_o,
  output logic        dmem_re_o,
  output logic        dmem_we_o,
  output logic        pc_load_o,
  output logic [1:0]  pc_sel_o,
  output logic        done_o,
  output logic        illegal_o
);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  ctrl_out_t   outs_q, outs_d;
  logic        slt_bit_q;

  logic [31:0] decWord;
  decode_t     dec;
  logic        branchInExec;
  logic        takeBranch;
  logic        unusedShamt;

  // Outputs are registered, so they are computed for the state being entered;
  // in IDLE that means decoding the incoming word rather than the latched one.
  assign decWord = (state_q == ST_IDLE) ? instr_i : instr_q;

  // The shift amount goes straight to the datapath, not through control
  assign unusedShamt = ^decWord[10:6];

  cpu54_ctrl_decode u_decode (
    .opcode_i (decWord[31:26]),
    .rt_i     (decWord[20:16]),
    .rd_i     (decWord[15:11]),
    .funct_i  (decWord[5:0]),
    .dec_o    (dec)
  );

  // Next state, then the control outputs that belong to that next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (instr_valid_i) state_d = ST_DECODE;
      ST_DECODE: state_d = dec.illegal ? ST_IDLE : ST_EXEC;
      ST_EXEC: begin
        case (dec.cls)
          CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_JR: state_d = ST_IDLE;
          CLS_LOAD, CLS_STORE:                      state_d = ST_MEM;
          default:                                  state_d = ST_WB;
        endcase
      end
      ST_MEM:    state_d = (dec.cls == CLS_LOAD) ? ST_WB : ST_IDLE;
      ST_WB:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (rst_i) state_d = ST_IDLE;

    outs_d = idleOutputs();
    if (state_d != ST_IDLE) begin
      outs_d.ready   = 1'b0;
      outs_d.aluc    = dec.aluc;
      outs_d.srcaSel = dec.srcaSel;
      outs_d.srcbSel = dec.srcbSel;
      outs_d.raddr1  = decWord[25:21];
      outs_d.raddr2  = decWord[20:16];
      outs_d.waddr   = dec.waddr;
    end
    case (state_d)
      ST_DECODE: begin
        if (dec.illegal) begin
          outs_d.done    = 1'b1;
          outs_d.illegal = 1'b1;
        end
      end
      ST_EXEC: begin
        case (dec.cls)
          CLS_J:  begin outs_d.pcSel = PC_JUMP; outs_d.done = 1'b1; end
          CLS_JR: begin outs_d.pcSel = PC_REG;  outs_d.done = 1'b1; end
          CLS_JAL: begin
            outs_d.rfWe  = (dec.waddr != 5'd0);
            outs_d.wbSel = WB_LINK;
            outs_d.pcSel = PC_JUMP;
            outs_d.done  = 1'b1;
          end
          CLS_BEQ, CLS_BNE: outs_d.done = 1'b1;
          default: ;
        endcase
      end
      ST_MEM: begin
        if (dec.cls == CLS_STORE) begin
          outs_d.dmemWe = 1'b1;
          outs_d.done   = 1'b1;
        end else begin
          outs_d.dmemRe = 1'b1;
        end
      end
      ST_WB: begin
        outs_d.rfWe = (dec.waddr != 5'd0);
        outs_d.done = 1'b1;
        case (dec.cls)
          CLS_SLT:  outs_d.wbSel = WB_SLT;
          CLS_LOAD: outs_d.wbSel = WB_MEM;
          default:  outs_d.wbSel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

  // State, latched instruction, registered outputs and the SLT flag capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      outs_q    <= idleOutputs();
      slt_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
      if (state_q == ST_IDLE && instr_valid_i) instr_q <= instr_i;
      if (state_q == ST_EXEC && dec.cls == CLS_SLT) slt_bit_q <= alu_negative_i;
    end
  end

  // Branch outcome has to follow the live zero flag during EXEC
  assign branchInExec = (state_q == ST_EXEC) &&
                        (dec.cls == CLS_BEQ || dec.cls == CLS_BNE);
  assign takeBranch   = (dec.cls == CLS_BEQ) ? alu_zero_i : !alu_zero_i;

  assign instr_ready_o = outs_q.ready;
  assign aluc_o        = outs_q.aluc;
  assign srca_sel_o    = outs_q.srcaSel;
  assign srcb_sel_o    = outs_q.srcbSel;
  assign rf_raddr1_o   = outs_q.raddr1;
  assign rf_raddr2_o   = outs_q.raddr2;
  assign rf_waddr_o    = outs_q.waddr;
  assign wb_sel_o      = outs_q.wbSel;
  assign slt_bit_o     = slt_bit_q;
  assign pc_sel_o      = branchInExec ? (takeBranch ? PC_BRANCH : PC_SEQ) : outs_q.pcSel;

  // A reset arriving mid-instruction must not let a strobe through
  assign rf_we_o   = outs_q.rfWe    & ~rst_i;
  assign dmem_re_o = outs_q.dmemRe  & ~rst_i;
  assign dmem_we_o = outs_q.dmemWe  & ~rst_i;
  assign done_o    = outs_q.done    & ~rst_i;
  assign illegal_o = outs_q.illegal & ~rst_i;
  assign pc_load_o = done_o;

endmodule

// File: tb/tb_cpu54_ctrl_fsm.sv
// Directed self-checking bench for the cpu54 control FSM.
module tb_cpu54_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_zero;
  logic        alu_negative;
  logic [3:0]  aluc;
  logic        srca_sel;
  logic [1:0]  srcb_sel;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [4:0]  rf_waddr;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        slt_bit;
  logic        dmem_re;
  logic        dmem_we;
  logic        pc_load;
  logic [1:0]  pc_sel;
  logic        done;
  logic        illegal;

  int assertions = 0;
  int failures   = 0;

  cpu54_ctrl_fsm dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_i        (instr),
    .instr_valid_i  (instr_valid),
    .instr_ready_o  (instr_ready),
    .alu_zero_i     (alu_zero),
    .alu_negative_i (alu_negative),
    .aluc_o         (aluc),
    .srca_sel_o     (srca_sel),
    .srcb_sel_o     (srcb_sel),
    .rf_raddr1_o    (rf_raddr1),
    .rf_raddr2_o    (rf_raddr2),
    .rf_waddr_o     (rf_waddr),
    .rf_we_o        (rf_we),
    .wb_sel_o       (wb_sel),
    .slt_bit_o      (slt_bit),
    .dmem_re_o      (dmem_re),
    .dmem_we_o      (dmem_we),
    .pc_load_o      (pc_load),
    .pc_sel_o       (pc_sel),
    .done_o         (done),
    .illegal_o      (illegal)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word while in IDLE; returns one step into DECODE (c1)
  task automatic applyStimulus(input logic [31:0] word);
    instr       = word;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed instruction steps
  initial begin
    rst          = 1'b1;
    instr        = '0;
    instr_valid  = 1'b0;
    alu_zero     = 1'b0;
    alu_negative = 1'b0;
    tick();
    tick();
    $display("[TB] reset values");
    checkOutput("rst_ready",   instr_ready, 1);
    checkOutput("rst_aluc",    aluc, 0);
    checkOutput("rst_srca",    srca_sel, 0);
    checkOutput("rst_srcb",    srcb_sel, 0);
    checkOutput("rst_wbsel",   wb_sel, 0);
    checkOutput("rst_pcsel",   pc_sel, 0);
    checkOutput("rst_sltbit",  slt_bit, 0);
    checkOutput("rst_strobes", {rf_we, dmem_re, dmem_we, pc_load, done, illegal}, 0);
    rst = 1'b0;
    tick();

    $display("[TB] add $3,$1,$2");
    checkOutput("add_c0_ready", instr_ready, 1);
    applyStimulus(32'h00221820);
    checkOutput("add_c1_ready", instr_ready, 0);
    checkOutput("add_c1_done",  done, 0);
    tick();
    checkOutput("add_c2_aluc",  aluc, 4'b0010);
    checkOutput("add_c2_srcb",  srcb_sel, 0);
    checkOutput("add_c2_done",  done, 0);
    checkOutput("add_c2_raddr", {rf_raddr1, rf_raddr2}, {5'd1, 5'd2});
    tick();
    checkOutput("add_c3_rfwe",   rf_we, 1);
    checkOutput("add_c3_waddr",  rf_waddr, 3);
    checkOutput("add_c3_wbsel",  wb_sel, 0);
    checkOutput("add_c3_done",   done, 1);
    checkOutput("add_c3_pcload", pc_load, 1);
    checkOutput("add_c3_pcsel",  pc_sel, 0);
    tick();
    checkOutput("add_c4_ready", instr_ready, 1);
    checkOutput("add_c4_done",  done, 0);

    $display("[TB] slt with negative flag set then clear");
    applyStimulus(32'h0022182A);
    tick();
    checkOutput("slt1_c2_aluc", aluc, 4'b1011);
    alu_negative = 1'b1;
    tick();
    alu_negative = 1'b0;
    checkOutput("slt1_c3_wbsel",  wb_sel, 1);
    checkOutput("slt1_c3_sltbit", slt_bit, 1);
    checkOutput("slt1_c3_rfwe",   rf_we, 1);
    tick();
    applyStimulus(32'h0022182A);
    tick();
    alu_negative = 1'b0;
    tick();
    checkOutput("slt0_c3_wbsel",  wb_sel, 1);
    checkOutput("slt0_c3_sltbit", slt_bit, 0);
    tick();

    $display("[TB] beq / bne");
    applyStimulus(32'h10220004);
    tick();
    alu_zero = 1'b1;
    #1;
    checkOutput("beq_z1_aluc",   aluc, 4'b0001);
    checkOutput("beq_z1_pcsel",  pc_sel, 1);
    checkOutput("beq_z1_done",   done, 1);
    checkOutput("beq_z1_pcload", pc_load, 1);
    alu_zero = 1'b0;
    #1;
    checkOutput("beq_z0_pcsel", pc_sel, 0);
    checkOutput("beq_z0_rfwe",  rf_we, 0);
    tick();
    checkOutput("beq_idle_ready", instr_ready, 1);
    applyStimulus(32'h14220004);
    tick();
    alu_zero = 1'b0;
    #1;
    checkOutput("bne_z0_pcsel", pc_sel, 1);
    checkOutput("bne_z0_done",  done, 1);
    alu_zero = 1'b1;
    #1;
    checkOutput("bne_z1_pcsel", pc_sel, 0);
    alu_zero = 1'b0;
    tick();

    $display("[TB] lw $5,8($4)");
    applyStimulus(32'h8C850008);
    tick();
    checkOutput("lw_c2_aluc", aluc, 4'b0000);
    checkOutput("lw_c2_srcb", srcb_sel, 1);
    tick();
    checkOutput("lw_c3_dmemre", dmem_re, 1);
    checkOutput("lw_c3_rfwe",   rf_we, 0);
    checkOutput("lw_c3_done",   done, 0);
    tick();
    checkOutput("lw_c4_rfwe",   rf_we, 1);
    checkOutput("lw_c4_waddr",  rf_waddr, 5);
    checkOutput("lw_c4_wbsel",  wb_sel, 2);
    checkOutput("lw_c4_done",   done, 1);
    checkOutput("lw_c4_dmemre", dmem_re, 0);
    tick();

    $display("[TB] illegal opcode with valid held high");
    instr       = 32'h7C000000;
    instr_valid = 1'b1;
    tick();
    checkOutput("ill_c1_done",    done, 1);
    checkOutput("ill_c1_illegal", illegal, 1);
    checkOutput("ill_c1_quiet",   {rf_we, dmem_re, dmem_we}, 0);
    checkOutput("ill_c1_ready",   instr_ready, 0);
    tick();
    checkOutput("ill_c2_ready", instr_ready, 1);
    checkOutput("ill_c2_done",  done, 0);
    tick();
    checkOutput("ill_c3_done",    done, 1);
    checkOutput("ill_c3_illegal", illegal, 1);
    instr_valid = 1'b0;
    tick();
    checkOutput("ill_c4_ready", instr_ready, 1);

    $display("[TB] sw $5,8($4)");
    applyStimulus(32'hAC850008);
    tick();
    checkOutput("sw_c2_aluc", aluc, 4'b0000);
    checkOutput("sw_c2_srcb", srcb_sel, 1);
    tick();
    checkOutput("sw_c3_dmemwe", dmem_we, 1);
    checkOutput("sw_c3_done",   done, 1);
    checkOutput("sw_c3_rfwe",   rf_we, 0);
    tick();

    $display("[TB] sw aborted by reset in c3");
    applyStimulus(32'hAC850008);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("swrst_c3_dmemwe", dmem_we, 0);
    checkOutput("swrst_c3_done",   done, 0);
    checkOutput("swrst_c3_pcload", pc_load, 0);
    tick();
    rst = 1'b0;
    checkOutput("swrst_c4_ready",  instr_ready, 1);
    checkOutput("swrst_c4_done",   done, 0);
    checkOutput("swrst_c4_dmemwe", dmem_we, 0);

    $display("[TB] jal");
    applyStimulus(32'h0C000010);
    tick();
    checkOutput("jal_c2_rfwe",  rf_we, 1);
    checkOutput("jal_c2_waddr", rf_waddr, 31);
    checkOutput("jal_c2_wbsel", wb_sel, 3);
    checkOutput("jal_c2_pcsel", pc_sel, 2);
    checkOutput("jal_c2_done",  done, 1);
    tick();

    $display("[TB] addu $0 suppresses the write");
    applyStimulus(32'h00220021);
    tick();
    tick();
    checkOutput("r0_c3_rfwe", rf_we, 0);
    checkOutput("r0_c3_done", done, 1);
    tick();

    $display("[TB] sll $3,$2,4");
    applyStimulus(32'h00021900);
    tick();
    checkOutput("sll_c2_srca", srca_sel, 1);
    checkOutput("sll_c2_aluc", aluc, 4'b1110);
    tick();
    tick();

    $display("[TB] andi $5,$4,0xFF");
    applyStimulus(32'h308500FF);
    tick();
    checkOutput("andi_c2_aluc", aluc, 4'b0100);
    checkOutput("andi_c2_srcb", srcb_sel, 2);
    tick();
    checkOutput("andi_c3_waddr", rf_waddr, 5);
    checkOutput("andi_c3_rfwe",  rf_we, 1);
    tick();

    $display("[TB] jr $31");
    applyStimulus(32'h03E00008);
    tick();
    checkOutput("jr_c2_pcsel",  pc_sel, 3);
    checkOutput("jr_c2_done",   done, 1);
    checkOutput("jr_c2_raddr1", rf_raddr1, 31);
    checkOutput("jr_c2_rfwe",   rf_we, 0);
    tick();
    checkOutput("jr_c3_ready", instr_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
